// File: rtl/timer_seq_ctrl.sv
// timer_seq_ctrl: turns CONFIG / SNAPSHOT / STOP / START commands into
// register sequences on a 16-bit interval-timer slave, and services the
// timer's timeout interrupt (clear status, count, pulse).
//
// Ports
//   clk, reset_n          clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready   command handshake; cmd_op 0=CONFIG 1=SNAPSHOT
//                         2=STOP 3=START, cmd_period/cmd_cont/cmd_ite for CONFIG
//   rsp_valid/rsp_data    one-cycle completion pulse, snapshot value (else 0)
//   tick_pulse/tick_count one-cycle pulse and wrapping count per serviced IRQ
//   tmr_*                 timer slave bus (word address, select, write strobe
//                         active-low, write data, read data one cycle later)
//   tmr_irq               timer interrupt, level
module timer_seq_ctrl #(
  parameter int unsigned TICK_W     = 16,
  parameter int unsigned IRQ_SVC_EN = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [31:0]       cmd_period,
  input  logic              cmd_cont,
  input  logic              cmd_ite,
  output logic              rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              tick_pulse,
  output logic [TICK_W-1:0] tick_count,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] CFG_STOP = 4'd1;
  localparam logic [3:0] CFG_PL   = 4'd2;
  localparam logic [3:0] CFG_PH   = 4'd3;
  localparam logic [3:0] CFG_CTRL = 4'd4;
  localparam logic [3:0] SNAP_W   = 4'd5;
  localparam logic [3:0] SNAP_RL  = 4'd6;
  localparam logic [3:0] SNAP_RH  = 4'd7;
  localparam logic [3:0] SNAP_CAP = 4'd8;
  localparam logic [3:0] CTRL_WR  = 4'd9;
  localparam logic [3:0] IRQ_CLR  = 4'd10;

  localparam logic [1:0] OP_CONFIG   = 2'd0;
  localparam logic [1:0] OP_SNAPSHOT = 2'd1;
  localparam logic [1:0] OP_STOP     = 2'd2;
  localparam logic [1:0] OP_START    = 2'd3;

  localparam logic [2:0] A_STATUS   = 3'd0;
  localparam logic [2:0] A_CONTROL  = 3'd1;
  localparam logic [2:0] A_PERIOD_L = 3'd2;
  localparam logic [2:0] A_PERIOD_H = 3'd3;
  localparam logic [2:0] A_SNAP_L   = 3'd4;
  localparam logic [2:0] A_SNAP_H   = 3'd5;

  // Control register image {stop, start, cont, ite}.
  function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                            input logic cont, input logic ite);
    return {12'd0, stop, start, cont, ite};
  endfunction

  logic [3:0]        state, state_n;
  logic [31:0]       period_q, period_n;
  logic              cont_q, cont_n, ite_q, ite_n;
  logic              cont_sh, cont_sh_n, ite_sh, ite_sh_n;
  logic [15:0]       snap_lo, snap_lo_n;
  logic [2:0]        addr_n;
  logic              cs_n, write_n_n;
  logic [15:0]       wdata_n;
  logic              rsp_valid_n, tick_pulse_n;
  logic [31:0]       rsp_data_n;
  logic [TICK_W-1:0] tick_count_n;
  logic              irq_svc;

  assign irq_svc   = tmr_irq && (IRQ_SVC_EN != 0);
  // Interrupt service takes priority, so an IRQ in IDLE holds off commands.
  assign cmd_ready = (state == IDLE) && !irq_svc;

  // State and registered outputs; bus registers carry the access of the state being entered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      period_q       <= 32'd0;
      cont_q         <= 1'b0;
      ite_q          <= 1'b0;
      cont_sh        <= 1'b0;
      ite_sh         <= 1'b0;
      snap_lo        <= 16'd0;
      tmr_address    <= 3'd0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= 16'd0;
      rsp_valid      <= 1'b0;
      rsp_data       <= 32'd0;
      tick_pulse     <= 1'b0;
      tick_count     <= '0;
    end else begin
      state          <= state_n;
      period_q       <= period_n;
      cont_q         <= cont_n;
      ite_q          <= ite_n;
      cont_sh        <= cont_sh_n;
      ite_sh         <= ite_sh_n;
      snap_lo        <= snap_lo_n;
      tmr_address    <= addr_n;
      tmr_chipselect <= cs_n;
      tmr_write_n    <= write_n_n;
      tmr_writedata  <= wdata_n;
      rsp_valid      <= rsp_valid_n;
      rsp_data       <= rsp_data_n;
      tick_pulse     <= tick_pulse_n;
      tick_count     <= tick_count_n;
    end
  end

  // Next state, next bus access and completion bookkeeping.
  always_comb begin
    state_n      = state;
    period_n     = period_q;
    cont_n       = cont_q;
    ite_n        = ite_q;
    cont_sh_n    = cont_sh;
    ite_sh_n     = ite_sh;
    snap_lo_n    = snap_lo;
    addr_n       = 3'd0;
    cs_n         = 1'b0;
    write_n_n    = 1'b1;
    wdata_n      = 16'd0;
    rsp_valid_n  = 1'b0;
    rsp_data_n   = rsp_data;
    tick_pulse_n = 1'b0;
    tick_count_n = tick_count;

    case (state)
      IDLE: begin
        if (irq_svc) begin
          state_n   = IRQ_CLR;
          cs_n      = 1'b1;
          write_n_n = 1'b0;
          addr_n    = A_STATUS;
        end else if (cmd_valid) begin
          period_n  = cmd_period;
          cont_n    = cmd_cont;
          ite_n     = cmd_ite;
          cs_n      = 1'b1;
          write_n_n = 1'b0;
          case (cmd_op)
            OP_CONFIG: begin
              state_n = CFG_STOP;
              addr_n  = A_CONTROL;
              wdata_n = ctrl_word(1'b1, 1'b0, 1'b0, 1'b0);
            end
            OP_SNAPSHOT: begin
              state_n = SNAP_W;
              addr_n  = A_SNAP_L;
            end
            OP_STOP: begin
              state_n = CTRL_WR;
              addr_n  = A_CONTROL;
              wdata_n = ctrl_word(1'b1, 1'b0, cont_sh, ite_sh);
            end
            default: begin
              state_n = CTRL_WR;
              addr_n  = A_CONTROL;
              wdata_n = ctrl_word(1'b0, 1'b1, cont_sh, ite_sh);
            end
          endcase
        end
      end
      CFG_STOP: begin
        state_n   = CFG_PL;
        cs_n      = 1'b1;
        write_n_n = 1'b0;
        addr_n    = A_PERIOD_L;
        wdata_n   = period_q[15:0];
      end
      CFG_PL: begin
        state_n   = CFG_PH;
        cs_n      = 1'b1;
        write_n_n = 1'b0;
        addr_n    = A_PERIOD_H;
        wdata_n   = period_q[31:16];
      end
      CFG_PH: begin
        state_n   = CFG_CTRL;
        cs_n      = 1'b1;
        write_n_n = 1'b0;
        addr_n    = A_CONTROL;
        wdata_n   = ctrl_word(1'b0, 1'b1, cont_q, ite_q);
      end
      CFG_CTRL: begin
        state_n     = IDLE;
        cont_sh_n   = cont_q;
        ite_sh_n    = ite_q;
        rsp_valid_n = 1'b1;
        rsp_data_n  = 32'd0;
      end
      CTRL_WR: begin
        state_n     = IDLE;
        rsp_valid_n = 1'b1;
        rsp_data_n  = 32'd0;
      end
      SNAP_W: begin
        state_n = SNAP_RL;
        cs_n    = 1'b1;
        addr_n  = A_SNAP_L;
      end
      SNAP_RL: begin
        state_n = SNAP_RH;
        cs_n    = 1'b1;
        addr_n  = A_SNAP_H;
      end
      // Read data lags the address by one cycle: low half arrives here.
      SNAP_RH: begin
        state_n   = SNAP_CAP;
        snap_lo_n = tmr_readdata;
      end
      SNAP_CAP: begin
        state_n     = IDLE;
        rsp_valid_n = 1'b1;
        rsp_data_n  = {tmr_readdata, snap_lo};
      end
      IRQ_CLR: begin
        state_n      = IDLE;
        tick_pulse_n = 1'b1;
        tick_count_n = tick_count + TICK_W'(1);
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// tb_timer_seq_ctrl: bench for timer_seq_ctrl with a behavioural timer slave,
// a bus monitor, a directed vector table and randomized commands checked
// against a command-level reference model.
module tb_timer_seq_ctrl;

  localparam int unsigned TICK_W = 8;
  localparam int TICK_MAX = (1 << TICK_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [31:0]       cmd_period;
  logic              cmd_cont;
  logic              cmd_ite;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              tick_pulse;
  logic [TICK_W-1:0] tick_count;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect;
  logic              tmr_write_n;
  logic [15:0]       tmr_writedata;
  logic [15:0]       tmr_readdata;
  logic              tmr_irq;

  always #5 clk = ~clk;

  timer_seq_ctrl #(.TICK_W(TICK_W), .IRQ_SVC_EN(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_cont(cmd_cont), .cmd_ite(cmd_ite),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .tick_pulse(tick_pulse), .tick_count(tick_count),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq)
  );

  // ---------------- timer slave model ----------------
  logic [31:0] tmr_counter;
  logic [3:0]  t_ctrl;
  logic [31:0] t_period, t_snap;
  logic        irq_pend, irq_raise, irq_hold;

  assign tmr_irq = irq_pend | irq_hold;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_pend <= 1'b0; tmr_readdata <= 16'd0; t_ctrl <= 4'd0;
      t_period <= 32'd0; t_snap <= 32'd0;
    end else begin
      if (irq_raise) irq_pend <= 1'b1;
      else if (tmr_chipselect && !tmr_write_n && tmr_address == 3'd0) irq_pend <= 1'b0;
      if (tmr_chipselect && tmr_write_n) begin
        case (tmr_address)
          3'd1:    tmr_readdata <= {12'd0, t_ctrl};
          3'd2:    tmr_readdata <= t_period[15:0];
          3'd3:    tmr_readdata <= t_period[31:16];
          3'd4:    tmr_readdata <= t_snap[15:0];
          3'd5:    tmr_readdata <= t_snap[31:16];
          default: tmr_readdata <= 16'd0;
        endcase
      end
      if (tmr_chipselect && !tmr_write_n) begin
        case (tmr_address)
          3'd1:    t_ctrl <= tmr_writedata[3:0];
          3'd2:    t_period[15:0] <= tmr_writedata;
          3'd3:    t_period[31:16] <= tmr_writedata;
          3'd4:    t_snap <= tmr_counter;
          default: ;
        endcase
      end
    end
  end

  // ---------------- bus / event monitor ----------------
  typedef struct packed { logic we; logic [2:0] addr; logic [15:0] data; } bus_t;
  bus_t bus_q[$];
  int   rsp_cnt = 0;
  int   pulse_cnt = 0;

  always @(negedge clk) begin : mon
    bus_t e;
    if (reset_n) begin
      if (tmr_chipselect) begin
        e.we   = !tmr_write_n;
        e.addr = tmr_address;
        e.data = tmr_write_n ? 16'd0 : tmr_writedata;
        bus_q.push_back(e);
      end
      if (rsp_valid)  rsp_cnt++;
      if (tick_pulse) pulse_cnt++;
    end
  end

  // ---------------- reference model ----------------
  bus_t exp_q[$];
  int   m_cont = 0, m_ite = 0, m_tick = 0;
  logic [3:0] m_ctrl = 4'd0;

  function automatic void ew(input logic we, input logic [2:0] addr, input logic [15:0] data);
    bus_t e;
    e.we = we; e.addr = addr; e.data = data;
    exp_q.push_back(e);
    if (we && addr == 3'd1) m_ctrl = data[3:0];
  endfunction

  // Expected timer accesses of one command, from the register map rules.
  function automatic void expect_cmd(input logic [1:0] op, input logic [31:0] period,
                                     input logic cont, input logic ite);
    case (op)
      2'd0: begin
        ew(1'b1, 3'd1, 16'h0008);
        ew(1'b1, 3'd2, period[15:0]);
        ew(1'b1, 3'd3, period[31:16]);
        ew(1'b1, 3'd1, 16'(4 + 2 * int'(cont) + int'(ite)));
        m_cont = int'(cont); m_ite = int'(ite);
      end
      2'd1: begin
        ew(1'b1, 3'd4, 16'd0);
        ew(1'b0, 3'd4, 16'd0);
        ew(1'b0, 3'd5, 16'd0);
      end
      2'd2:    ew(1'b1, 3'd1, 16'(8 + 2 * m_cont + m_ite));
      default: ew(1'b1, 3'd1, 16'(4 + 2 * m_cont + m_ite));
    endcase
  endfunction

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] period, input logic cont,
                      input logic ite, input logic [31:0] counter, input bit irq_first,
                      input bit irq_mid, input int exp_lat, input logic [31:0] exp_rsp,
                      input string tag);
    int base, rbase, pbase, lat, wt, bad;
    exp_q.delete();
    @(negedge clk);
    tmr_counter = counter;
    base = bus_q.size(); rbase = rsp_cnt; pbase = pulse_cnt;
    if (irq_first) begin
      irq_raise = 1'b1;
      @(negedge clk);
      irq_raise = 1'b0;
      ew(1'b1, 3'd0, 16'd0);
      m_tick++;
    end
    cmd_op = op; cmd_period = period; cmd_cont = cont; cmd_ite = ite; cmd_valid = 1'b1;
    if (irq_first) chk({tag, "_ready_irq"}, 32'(cmd_ready), 32'd0);
    expect_cmd(op, period, cont, ite);
    wt = 0;
    while (!cmd_ready && wt < 20) begin @(negedge clk); wt++; end
    chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_period = $urandom; cmd_cont = 1'($urandom); cmd_ite = 1'($urandom);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      irq_raise = irq_mid && lat == 1;
    end while (!rsp_valid && lat < 40);
    irq_raise = 1'b0;
    if (irq_mid) begin ew(1'b1, 3'd0, 16'd0); m_tick++; end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rsp_data"}, rsp_data, exp_rsp);
    @(negedge clk);
    chk({tag, "_rsp_single"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_hold"}, rsp_data, exp_rsp);
    repeat (4) @(negedge clk);
    chk({tag, "_bus_len"}, 32'(bus_q.size() - base), 32'(exp_q.size()));
    bad = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= bus_q.size() || bus_q[base + i] != exp_q[i]) bad++;
    chk({tag, "_bus_trace"}, 32'(bad), 32'd0);
    chk({tag, "_rsp_count"}, 32'(rsp_cnt - rbase), 32'd1);
    chk({tag, "_pulses"}, 32'(pulse_cnt - pbase), 32'(int'(irq_first) + int'(irq_mid)));
    chk({tag, "_tick"}, 32'(tick_count), 32'(m_tick % (TICK_MAX + 1)));
    chk({tag, "_ctrl"}, 32'(t_ctrl), 32'(m_ctrl));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] period;
    logic        cont, ite;
    logic [31:0] counter;
    bit          irq_first;
    int          exp_lat;
    logic [31:0] exp_rsp;
    logic [3:0]  exp_ctrl;
  } vec_t;

  vec_t tbl[9];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int wt, pbase, rbase, lat, exp_lat;
    logic [1:0]  op;
    logic [31:0] cnt;
    bit irq_f, irq_m;

    tbl[0] = '{2'd0, 32'h000F_4240, 1'b1, 1'b1, 32'h0,         1'b0, 5, 32'h0,         4'h7};
    tbl[1] = '{2'd1, 32'h0,         1'b0, 1'b0, 32'h0001_2345, 1'b0, 5, 32'h0001_2345, 4'h7};
    tbl[2] = '{2'd0, 32'h1234_5678, 1'b1, 1'b0, 32'h0,         1'b0, 5, 32'h0,         4'h6};
    tbl[3] = '{2'd2, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 2, 32'h0,         4'hA};
    tbl[4] = '{2'd3, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 2, 32'h0,         4'h6};
    tbl[5] = '{2'd0, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0,         1'b1, 5, 32'h0,         4'h5};
    tbl[6] = '{2'd2, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 2, 32'h0,         4'h9};
    tbl[7] = '{2'd1, 32'h0,         1'b0, 1'b0, 32'hFFFF_0000, 1'b1, 5, 32'hFFFF_0000, 4'h9};
    tbl[8] = '{2'd3, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0, 2, 32'h0,         4'h5};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_period = 32'd0;
    cmd_cont = 1'b0; cmd_ite = 1'b0; irq_raise = 1'b0; irq_hold = 1'b0; tmr_counter = 32'd0;
    repeat (3) @(negedge clk);
    chk("reset_cs", 32'(tmr_chipselect), 32'd0);
    chk("reset_write_n", 32'(tmr_write_n), 32'd1);
    chk("reset_addr", 32'(tmr_address), 32'd0);
    chk("reset_wdata", 32'(tmr_writedata), 32'd0);
    chk("reset_rsp", 32'(rsp_valid), 32'd0);
    chk("reset_rsp_data", rsp_data, 32'd0);
    chk("reset_tick", 32'(tick_count), 32'd0);
    chk("reset_pulse", 32'(tick_pulse), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Directed vectors.
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].op, tbl[i].period, tbl[i].cont, tbl[i].ite, tbl[i].counter,
           tbl[i].irq_first, 1'b0, tbl[i].exp_lat, tbl[i].exp_rsp, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ctrl_tbl", i), 32'(t_ctrl), 32'(tbl[i].exp_ctrl));
    end

    // Interrupt arriving mid-command is deferred until the command completes.
    send(2'd0, 32'h0000_00FF, 1'b1, 1'b1, 32'h0, 1'b0, 1'b1, 5, 32'h0, "mid_cfg");
    send(2'd2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 2, 32'h0, "mid_stop");
    send(2'd1, 32'h0, 1'b0, 1'b0, 32'hA5A5_5A5A, 1'b0, 1'b1, 5, 32'hA5A5_5A5A, "mid_snap");

    // Counter wrap: run up to the maximum with a held interrupt, then one more.
    irq_hold = 1'b1;
    wt = 0;
    while (int'(tick_count) != TICK_MAX && wt < 4000) begin @(negedge clk); wt++; end
    irq_hold = 1'b0;
    repeat (3) @(negedge clk);
    chk("wrap_at_max", 32'(tick_count), 32'(TICK_MAX));
    pbase = pulse_cnt;
    irq_raise = 1'b1;
    @(negedge clk);
    irq_raise = 1'b0;
    wt = 0;
    while (!tick_pulse && wt < 20) begin @(negedge clk); wt++; end
    chk("wrap_pulse", 32'(tick_pulse), 32'd1);
    chk("wrap_zero", 32'(tick_count), 32'd0);
    @(negedge clk);
    chk("wrap_pulse_single", 32'(tick_pulse), 32'd0);
    chk("wrap_pulse_count", 32'(pulse_cnt - pbase), 32'd1);
    m_tick = 0;

    // Randomized commands against the reference model.
    for (int i = 0; i < 30; i++) begin
      op      = 2'($urandom_range(0, 3));
      cnt     = $urandom;
      irq_f   = $urandom_range(0, 3) == 0;
      irq_m   = !irq_f && $urandom_range(0, 4) == 0;
      exp_lat = (op == 2'd0 || op == 2'd1) ? 5 : 2;
      send(op, $urandom, 1'($urandom), 1'($urandom), cnt, irq_f, irq_m, exp_lat,
           (op == 2'd1) ? cnt : 32'd0, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a CONFIG abandons it without a response.
    @(negedge clk);
    cmd_op = 2'd0; cmd_period = 32'h0BAD_F00D; cmd_cont = 1'b1; cmd_ite = 1'b1; cmd_valid = 1'b1;
    wt = 0;
    while (!cmd_ready && wt < 20) begin @(negedge clk); wt++; end
    chk("rst_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rbase = rsp_cnt;
    for (lat = 0; lat < 3; lat++) @(negedge clk);
    chk("rst_in_cfg_ph", 32'(tmr_address), 32'd3);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cs", 32'(tmr_chipselect), 32'd0);
    chk("rst_mid_write_n", 32'(tmr_write_n), 32'd1);
    chk("rst_mid_addr", 32'(tmr_address), 32'd0);
    chk("rst_mid_wdata", 32'(tmr_writedata), 32'd0);
    chk("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    chk("rst_mid_rsp_data", rsp_data, 32'd0);
    chk("rst_mid_tick", 32'(tick_count), 32'd0);
    m_tick = 0; m_cont = 0; m_ite = 0; m_ctrl = 4'd0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_no_rsp", 32'(rsp_cnt - rbase), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    // Shadow bits were cleared, so STOP writes plain stop.
    send(2'd2, 32'h0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0, 2, 32'h0, "post_rst_stop");
    chk("post_rst_stop_word", 32'(t_ctrl), 32'h8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
